// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Signed operations iterate on magnitudes and fix up signs in a final cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             abortE,
    input  logic             mthiE,
    input  logic             mtloE,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d, work_lo_q, work_lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic             done_c;

    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign op_signed = ~opE[0];
    assign a_neg     = op_signed & srcaE[WIDTH-1];
    assign b_neg     = op_signed & srcbE[WIDTH-1];
    assign a_mag     = a_neg ? -srcaE : srcaE;
    assign b_mag     = b_neg ? -srcbE : srcbE;

    // Multiply: add multiplicand when the low bit of the multiplier is set, then shift right.
    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

    assign prod_fix  = neg_q ? -{work_hi_q, work_lo_q} : {work_hi_q, work_lo_q};
    assign quot_fix  = neg_q ? -work_lo_q : work_lo_q;
    assign rem_fix   = neg_rem_q ? -work_hi_q : work_hi_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        work_hi_d  = work_hi_q;
        work_lo_d  = work_lo_q;
        b_d        = b_q;
        dividend_d = dividend_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mthiE) hi_d = srcaE;
                if (mtloE) lo_d = srcaE;
                if (startE && !abortE) begin
                    is_div_d   = opE[1];
                    neg_d      = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (srcbE == '0);
                    dividend_d = srcaE;
                    b_d        = b_mag;
                    work_hi_d  = '0;
                    work_lo_d  = a_mag;
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (abortE) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            work_hi_d = div_diff[WIDTH-1:0];
                            work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            work_hi_d = div_shift[WIDTH-1:0];
                            work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {work_hi_d, work_lo_d} = {mul_sum, work_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                // done is gated by abortE in this same cycle, so it cannot be a pure flop.
                if (!abortE) begin
                    done_c = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (div_zero_q) begin
                        hi_d = dividend_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            work_hi_q  <= '0;
            work_lo_q  <= '0;
            b_q        <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            work_hi_q  <= work_hi_d;
            work_lo_q  <= work_lo_d;
            b_q        <= b_d;
            dividend_q <= dividend_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_c;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed boundary cases plus random ops
// compared against a plain-arithmetic reference model, on 32-bit and 8-bit instances.
module tb_mips_muldiv_unit;
    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          done32_cnt = 0;

    logic        rst32, start32, abort32, mthi32, mtlo32, busy32, done32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic [31:0] exp_hi, exp_lo;

    logic        rst8, start8, abort8, mthi8, mtlo8, busy8, done8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst32), .startE(start32), .opE(op32), .srcaE(a32), .srcbE(b32),
        .abortE(abort32), .mthiE(mthi32), .mtloE(mtlo32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    mips_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .startE(start8), .opE(op8), .srcaE(a8), .srcbE(b8),
        .abortE(abort8), .mthiE(mthi8), .mtloE(mtlo8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    always @(negedge clk) if (done32 === 1'b1) done32_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} straight from integer arithmetic on the operands.
    function automatic logic [63:0] ref32(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            2'd0: begin
                q = sa * sb;
                p = q;
            end
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Runs one op; a junk start in cycle 5 and MTHI/MTLO in cycle 7 must be ignored.
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [63:0] e;
        e = ref32(op, a, b);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        tick();
        for (int c = 1; c < 33; c++) begin
            if (c == 1)  check({tag, " busy@1"}, 64'(busy32), 64'd1);
            if (c == 32) check({tag, " done@32"}, 64'(done32), 64'd0);
            start32 = (c == 5);
            mthi32  = (c == 7);
            mtlo32  = (c == 7);
            op32    = 2'($urandom);
            a32     = $urandom;
            b32     = $urandom;
            tick();
        end
        start32 = 1'b0; mthi32 = 1'b0; mtlo32 = 1'b0;
        check({tag, " done@33"}, 64'(done32), 64'd1);
        tick();
        check({tag, " done@34"}, 64'(done32), 64'd0);
        check({tag, " busy@34"}, 64'(busy32), 64'd0);
        check({tag, " hilo"}, {hi32, lo32}, e);
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (%s)", op, a, b, hi32, lo32, tag);
    endtask

    initial begin
        int          cnt0;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst32 = 1'b1; start32 = 0; abort32 = 0; mthi32 = 0; mtlo32 = 0; op32 = 0; a32 = 0; b32 = 0;
        rst8  = 1'b1; start8  = 0; abort8  = 0; mthi8  = 0; mtlo8  = 0; op8  = 0; a8  = 0; b8  = 0;
        repeat (3) tick();
        rst32 = 1'b0; rst8 = 1'b0;
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset hilo", {hi32, lo32}, 64'd0);
        check("reset8 hilo", {48'd0, hi8, lo8}, 64'd0);
        exp_hi = 0; exp_lo = 0;

        run32(2'd0, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
        check("mult -3*7 const", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFEB);
        run32(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
        check("multu max const", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
        run32(2'd2, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        check("div -7/2 const", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);
        run32(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        check("div ovf const", {hi32, lo32}, 64'h0000_0000_8000_0000);
        run32(2'd3, 32'h0000_0064, 32'd0, "divu /0");
        check("divu /0 const", {hi32, lo32}, 64'h0000_0064_FFFF_FFFF);
        run32(2'd2, 32'hFFFF_FF00, 32'd0, "div /0");

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 300));
                default: ;
            endcase
            run32(rop, ra, rb, "random");
        end

        // Abort in RUN: no done, hi/lo keep prior values.
        cnt0 = done32_cnt;
        start32 = 1'b1; op32 = 2'd1; a32 = 32'd5; b32 = 32'd6;
        tick();
        start32 = 1'b0;
        repeat (9) tick();
        abort32 = 1'b1;
        tick();
        abort32 = 1'b0;
        check("abort busy", 64'(busy32), 64'd0);
        check("abort hilo", {hi32, lo32}, {exp_hi, exp_lo});
        repeat (30) tick();
        check("abort no done", 64'(done32_cnt), 64'(cnt0));
        $display("abort in RUN: busy=%b hi=%h lo=%h", busy32, hi32, lo32);

        mthi32 = 1'b1; a32 = 32'h0000_ABCD;
        tick();
        mthi32 = 1'b0;
        exp_hi = 32'h0000_ABCD;
        check("mthi idle", {hi32, lo32}, {exp_hi, exp_lo});
        $display("mthi idle: hi=%h", hi32);

        // Abort arriving in FIX suppresses both the write and done.
        start32 = 1'b1; op32 = 2'd0; a32 = 32'd9; b32 = 32'd9;
        tick();
        start32 = 1'b0;
        repeat (32) tick();
        abort32 = 1'b1;
        #1;
        check("abort fix done", 64'(done32), 64'd0);
        tick();
        abort32 = 1'b0;
        check("abort fix busy", 64'(busy32), 64'd0);
        check("abort fix hilo", {hi32, lo32}, {exp_hi, exp_lo});
        $display("abort in FIX: hi=%h lo=%h", hi32, lo32);

        start32 = 1'b1; abort32 = 1'b1; op32 = 2'd1; a32 = 32'd3; b32 = 32'd3;
        tick();
        start32 = 1'b0; abort32 = 1'b0;
        check("start+abort idle", 64'(busy32), 64'd0);

        mthi32 = 1'b1; mtlo32 = 1'b1; a32 = 32'h1234_5678;
        tick();
        mthi32 = 1'b0; mtlo32 = 1'b0;
        check("mthi+mtlo", {hi32, lo32}, 64'h1234_5678_1234_5678);
        $display("mthi+mtlo: hi=%h lo=%h", hi32, lo32);

        // MTHI alongside a start: immediate write, later overwritten by the result.
        mthi32 = 1'b1; start32 = 1'b1; op32 = 2'd3; a32 = 32'd100; b32 = 32'd7;
        tick();
        mthi32 = 1'b0; start32 = 1'b0;
        check("mthi+start hi", 64'(hi32), 64'd100);
        repeat (33) tick();
        check("mthi+start result", {hi32, lo32}, ref32(2'd3, 32'd100, 32'd7));
        $display("mthi+start: hi=%h lo=%h", hi32, lo32);

        // 8-bit instance: MULT 0x80 * 0x80 and reset mid-operation.
        start8 = 1'b1; op8 = 2'd0; a8 = 8'h80; b8 = 8'h80;
        tick();
        start8 = 1'b0;
        repeat (7) tick();
        check("w8 done@8", 64'(done8), 64'd0);
        tick();
        check("w8 done@9", 64'(done8), 64'd1);
        tick();
        check("w8 mult hilo", {48'd0, hi8, lo8}, 64'h4000);
        $display("w8 mult 80*80: hi=%h lo=%h", hi8, lo8);

        start8 = 1'b1; op8 = 2'd1; a8 = 8'hFF; b8 = 8'hFF;
        tick();
        start8 = 1'b0;
        repeat (2) tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("w8 reset busy", 64'(busy8), 64'd0);
        check("w8 reset hilo", {48'd0, hi8, lo8}, 64'd0);
        $display("w8 reset mid-op: busy=%b hi=%h lo=%h", busy8, hi8, lo8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
